// File: rtl/wt_time_scan.sv
// Watch time-of-day core: 1 s prescaler, BCD HH:MM:SS counter with set keys, 6-digit scan mux.
// Optional: define WT_LEAD_ZERO_BLANK_EN to blank a leading-zero hour-tens digit (BCD=4'hF).
module wt_time_scan #(
    parameter int CLK_DIV_SEC = 1000,
    parameter int SCAN_DIV    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SET_MODE,
    input  logic       INC_H,
    input  logic       INC_M,
    input  logic       CLR_SEC,
    output logic [3:0] BCD,
    output logic       DOT,
    output logic [5:0] DIGIT,
    output logic       SEC_TICK
);

    localparam int PW = $clog2(CLK_DIV_SEC);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV_SEC - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    s_u_q, s_u_d, s_t_q, s_t_d;
    logic [3:0]    m_u_q, m_u_d, m_t_q, m_t_d;
    logic [3:0]    h_u_q, h_u_d, h_t_q, h_t_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          dot_q, dot_d;
    logic [5:0]    digit_q, digit_d;
    logic          tick_q, tick_d;

    logic tick, adv_s, adv_m, adv_h, s_wrap, m_wrap;

    always_comb begin
        tick   = (pre_q == PRE_MAX) && !SET_MODE;
        adv_s  = tick && !CLR_SEC;
        s_wrap = (s_u_q == 4'd9) && (s_t_q == 4'd5);
        m_wrap = (m_u_q == 4'd9) && (m_t_q == 4'd5);
        // Set-mode increments and tick carries are mutually exclusive (no tick in set mode).
        adv_m  = (adv_s && s_wrap) || (SET_MODE && INC_M);
        adv_h  = (adv_s && s_wrap && m_wrap) || (SET_MODE && INC_H);

        pre_d  = (SET_MODE || CLR_SEC || pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        tick_d = adv_s;

        s_u_d = s_u_q;
        s_t_d = s_t_q;
        m_u_d = m_u_q;
        m_t_d = m_t_q;
        h_u_d = h_u_q;
        h_t_d = h_t_q;

        if (CLR_SEC) begin
            s_u_d = '0;
            s_t_d = '0;
        end else if (adv_s) begin
            if (s_u_q == 4'd9) begin
                s_u_d = '0;
                s_t_d = (s_t_q == 4'd5) ? '0 : s_t_q + 4'd1;
            end else begin
                s_u_d = s_u_q + 4'd1;
            end
        end

        if (adv_m) begin
            if (m_u_q == 4'd9) begin
                m_u_d = '0;
                m_t_d = (m_t_q == 4'd5) ? '0 : m_t_q + 4'd1;
            end else begin
                m_u_d = m_u_q + 4'd1;
            end
        end

        if (adv_h) begin
            if (h_t_q == 4'd2 && h_u_q == 4'd3) begin
                h_u_d = '0;
                h_t_d = '0;
            end else if (h_u_q == 4'd9) begin
                h_u_d = '0;
                h_t_d = h_t_q + 4'd1;
            end else begin
                h_u_d = h_u_q + 4'd1;
            end
        end

        if (scan_q == SCAN_MAX) begin
            scan_d = '0;
            idx_d  = (idx_q == 3'd5) ? '0 : idx_q + 3'd1;
        end else begin
            scan_d = scan_q + 1'b1;
            idx_d  = idx_q;
        end

        case (idx_q)
            3'd0:    bcd_d = s_u_q;
            3'd1:    bcd_d = s_t_q;
            3'd2:    bcd_d = m_u_q;
            3'd3:    bcd_d = m_t_q;
            3'd4:    bcd_d = h_u_q;
            3'd5:    bcd_d = h_t_q;
            default: bcd_d = '0;
        endcase
`ifdef WT_LEAD_ZERO_BLANK_EN
        if (idx_q == 3'd5 && h_t_q == 4'd0) bcd_d = 4'hF;
`endif
        dot_d   = (idx_q == 3'd2) || (idx_q == 3'd4);
        digit_d = 6'b000001 << idx_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q   <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            s_u_q   <= '0;
            s_t_q   <= '0;
            m_u_q   <= '0;
            m_t_q   <= '0;
            h_u_q   <= '0;
            h_t_q   <= '0;
            bcd_q   <= '0;
            dot_q   <= 1'b0;
            digit_q <= 6'b000001;
            tick_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            s_u_q   <= s_u_d;
            s_t_q   <= s_t_d;
            m_u_q   <= m_u_d;
            m_t_q   <= m_t_d;
            h_u_q   <= h_u_d;
            h_t_q   <= h_t_d;
            bcd_q   <= bcd_d;
            dot_q   <= dot_d;
            digit_q <= digit_d;
            tick_q  <= tick_d;
        end
    end

    assign BCD      = bcd_q;
    assign DOT      = dot_q;
    assign DIGIT    = digit_q;
    assign SEC_TICK = tick_q;

endmodule

// File: tb/tb_wt_time_scan.sv
// Scoreboard bench for wt_time_scan: seconds-of-day reference model, queue of expected outputs per edge.
module tb_wt_time_scan;

    localparam int CDIV = 10;
    localparam int SDIV = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SET_MODE = 1'b0;
    logic       INC_H = 1'b0;
    logic       INC_M = 1'b0;
    logic       CLR_SEC = 1'b0;
    logic [3:0] BCD;
    logic       DOT;
    logic [5:0] DIGIT;
    logic       SEC_TICK;

    wt_time_scan #(.CLK_DIV_SEC(CDIV), .SCAN_DIV(SDIV)) dut (
        .CLK(CLK), .RST(RST), .SET_MODE(SET_MODE), .INC_H(INC_H), .INC_M(INC_M),
        .CLR_SEC(CLR_SEC), .BCD(BCD), .DOT(DOT), .DIGIT(DIGIT), .SEC_TICK(SEC_TICK)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       tick;
        logic [3:0] bcd;
        logic       dot;
        logic [5:0] dig;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   t_sec, pre, scnt, sidx;
    bit   cur_set;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        t_sec = 0;
        pre   = 0;
        scnt  = 0;
        sidx  = 0;
    endtask

    // Expected outputs after the coming edge, then advance the model across that edge.
    task automatic model_push(input bit set, input bit ih, input bit im, input bit cl);
        exp_t e;
        int   h, m, s, d;
        bit   tk;
        h = t_sec / 3600;
        m = (t_sec / 60) % 60;
        s = t_sec % 60;
        case (sidx)
            0:       d = s % 10;
            1:       d = s / 10;
            2:       d = m % 10;
            3:       d = m / 10;
            4:       d = h % 10;
            default: d = h / 10;
        endcase
`ifdef WT_LEAD_ZERO_BLANK_EN
        if (sidx == 5 && h / 10 == 0) d = 15;
`endif
        tk     = (pre == CDIV - 1) && !set;
        e.tick = tk && !cl;
        e.bcd  = 4'(d);
        e.dot  = (sidx == 2) || (sidx == 4);
        e.dig  = 6'(1 << sidx);
        q.push_back(e);

        if (tk && !cl) t_sec = (t_sec + 1) % 86400;
        h = t_sec / 3600;
        m = (t_sec / 60) % 60;
        s = t_sec % 60;
        if (set && im) m = (m + 1) % 60;
        if (set && ih) h = (h + 1) % 24;
        if (cl) s = 0;
        t_sec = h * 3600 + m * 60 + s;
        pre = (set || cl || pre == CDIV - 1) ? 0 : pre + 1;
        if (scnt == SDIV - 1) begin
            scnt = 0;
            sidx = (sidx + 1) % 6;
        end else begin
            scnt++;
        end
    endtask

    task automatic step(input bit set, input bit ih, input bit im, input bit cl);
        @(negedge CLK);
        SET_MODE = set;
        INC_H    = ih;
        INC_M    = im;
        CLR_SEC  = cl;
        model_push(set, ih, im, cl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(cur_set, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset is applied between edges, so the checks below see the asynchronous path only.
    task automatic reset_dut();
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("rst_digit", int'(DIGIT), 1);
        chk("rst_bcd", int'(BCD), 0);
        chk("rst_dot", int'(DOT), 0);
        chk("rst_tick", int'(SEC_TICK), 0);
        #1;
        RST      = 1'b0;
        cur_set  = 1'b0;
        SET_MODE = 1'b0;
        INC_H    = 1'b0;
        INC_M    = 1'b0;
        CLR_SEC  = 1'b0;
        q.delete();
        model_reset();
        model_push(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_hm(input int hh, input int mm);
        cur_set = 1'b1;
        for (int i = 0; i < hh; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < mm; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_until_sec(input int target);
        int guard;
        guard = 0;
        cur_set = 1'b0;
        while (t_sec != target && guard < 2000) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("reach_time", t_sec, target);
    endtask

    exp_t mon_e;
    always @(negedge CLK) begin
        if (!RST && q.size() != 0) begin
            mon_e = q.pop_front();
            chk("sec_tick", int'(SEC_TICK), int'(mon_e.tick));
            chk("digit", int'(DIGIT), int'(mon_e.dig));
            chk("bcd", int'(BCD), int'(mon_e.bcd));
            chk("dot", int'(DOT), int'(mon_e.dot));
        end
    end

    initial begin
        cur_set = 1'b0;
        model_reset();
        #22;
        reset_dut();
        idle(25);

        // 23:59:59 rollover
        reset_dut();
        set_hm(23, 59);
        run_until_sec(86399);
        idle(30);

        // set keys: minute wrap without carry, hour wrap, simultaneous keys, ignored keys
        reset_dut();
        set_hm(0, 58);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        set_hm(23, 0);
        idle(12);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(12);
        set_hm(5, 6);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(12);
        cur_set = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(14);

        // clear seconds on the tick cycle at 00:00:59
        reset_dut();
        run_until_sec(59);
        while (pre != CDIV - 1) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(15);

        // 12:34:56 scan sequence, then 07:00:00 hour-tens, then mid-scan reset
        reset_dut();
        set_hm(12, 34);
        run_until_sec(12 * 3600 + 34 * 60 + 56);
        cur_set = 1'b1;
        idle(14);
        reset_dut();
        set_hm(7, 0);
        idle(13);
        reset_dut();

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0) cur_set = !cur_set;
            step(cur_set, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 99) == 0) || (pre == CDIV - 1 && $urandom_range(0, 9) == 0));
            if ($urandom_range(0, 499) == 0) reset_dut();
        end

        @(negedge CLK);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
